// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential/stall/redirect/trap/call/ret next-pc
// selection, saved exception pc and a circular return-address stack.
module pc_unit #(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          INC       = 4,
  parameter logic [WIDTH-1:0]     RESET_VEC = '0,
  parameter logic [WIDTH-1:0]     TRAP_VEC  = 32'h0000_1000,
  parameter int unsigned          RAS_DEPTH = 4,
  localparam int unsigned         PW        = $clog2(RAS_DEPTH),
  localparam int unsigned         CW        = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap,
  input  logic             mret,
  input  logic             call,
  input  logic [WIDTH-1:0] call_target,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] epc,
  output logic [CW-1:0]    ras_count,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [PW-1:0]    TOP_ONE = PW'(1);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    top_up;
  logic             push, pop;

  assign pc_inc    = pc + INC_W;
  assign top_up    = top + TOP_ONE;
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == DEPTH_C);

  // Priority chain; redirect-class inputs override stall, stall blocks call/ret.
  always_comb begin
    next_pc = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    if (trap)                      next_pc = TRAP_VEC;
    else if (mret)                 next_pc = epc;
    else if (redirect_valid)       next_pc = redirect_target;
    else if (stall)                next_pc = pc;
    else if (call) begin
      next_pc = call_target;
      push    = 1'b1;
    end else if (ret && !ras_empty) begin
      next_pc = ras[top];
      pop     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_VEC;
      epc       <= '0;
      top       <= '0;
      ras_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      pc <= next_pc;
      if (trap) epc <= pc;
      if (push) begin
        // Full stack wraps onto the oldest entry; count saturates.
        top         <= top_up;
        ras[top_up] <= pc_inc;
        if (!ras_full) ras_count <= ras_count + CNT_ONE;
      end else if (pop) begin
        top       <= top - TOP_ONE;
        ras_count <= ras_count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit with default parameters.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect_valid, trap, mret, call, ret;
  logic [31:0] redirect_target, call_target;
  logic [31:0] pc, next_pc, epc;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full;

  int n_cmp = 0;
  int n_bad = 0;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap(trap), .mret(mret), .call(call),
    .call_target(call_target), .ret(ret), .pc(pc), .next_pc(next_pc),
    .epc(epc), .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, rv, tr, mr, ca, re;
    logic [31:0] rt, ct;
    logic [31:0] e_next, e_pc, e_epc;
    logic [2:0]  e_cnt;
    logic        e_full;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic v(input logic st, rv, input logic [31:0] rt, input logic tr, mr, ca,
                   input logic [31:0] ct, input logic re, input logic [31:0] e_next,
                   e_pc, e_epc, input logic [2:0] e_cnt, input logic e_full);
    vec_t t;
    t.st = st; t.rv = rv; t.rt = rt; t.tr = tr; t.mr = mr; t.ca = ca; t.ct = ct;
    t.re = re; t.e_next = e_next; t.e_pc = e_pc; t.e_epc = e_epc;
    t.e_cnt = e_cnt; t.e_full = e_full;
    tbl.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    stall = t.st; redirect_valid = t.rv; redirect_target = t.rt; trap = t.tr;
    mret = t.mr; call = t.ca; call_target = t.ct; ret = t.re;
  endtask

  task automatic idle();
    stall = 0; redirect_valid = 0; redirect_target = 0; trap = 0;
    mret = 0; call = 0; call_target = 0; ret = 0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    //  st rv rt            tr mr ca ct           re next          pc            epc        cnt full
    v(0, 0, 0,             0, 0, 0, 0,           0, 32'h4,        32'h4,        0,         0, 0);
    v(0, 0, 0,             0, 0, 0, 0,           0, 32'h8,        32'h8,        0,         0, 0);
    v(0, 0, 0,             0, 0, 0, 0,           0, 32'hC,        32'hC,        0,         0, 0);
    v(0, 1, 32'h100,       0, 0, 0, 0,           0, 32'h100,      32'h100,      0,         0, 0);
    v(0, 0, 0,             0, 0, 1, 32'h400,     0, 32'h400,      32'h400,      0,         1, 0);
    v(0, 0, 0,             0, 0, 0, 0,           1, 32'h104,      32'h104,      0,         0, 0);
    // five calls into a 4-deep stack, then five returns
    v(0, 1, 32'h0,         0, 0, 0, 0,           0, 32'h0,        32'h0,        0,         0, 0);
    v(0, 0, 0,             0, 0, 1, 32'h10,      0, 32'h10,       32'h10,       0,         1, 0);
    v(0, 0, 0,             0, 0, 1, 32'h20,      0, 32'h20,       32'h20,       0,         2, 0);
    v(0, 0, 0,             0, 0, 1, 32'h30,      0, 32'h30,       32'h30,       0,         3, 0);
    v(0, 0, 0,             0, 0, 1, 32'h40,      0, 32'h40,       32'h40,       0,         4, 1);
    v(0, 0, 0,             0, 0, 1, 32'h500,     0, 32'h500,      32'h500,      0,         4, 1);
    v(0, 0, 0,             0, 0, 0, 0,           1, 32'h44,       32'h44,       0,         3, 0);
    v(0, 0, 0,             0, 0, 0, 0,           1, 32'h34,       32'h34,       0,         2, 0);
    v(0, 0, 0,             0, 0, 0, 0,           1, 32'h24,       32'h24,       0,         1, 0);
    v(0, 0, 0,             0, 0, 0, 0,           1, 32'h14,       32'h14,       0,         0, 0);
    v(0, 0, 0,             0, 0, 0, 0,           1, 32'h18,       32'h18,       0,         0, 0);
    // stall interactions
    v(0, 1, 32'h200,       0, 0, 0, 0,           0, 32'h200,      32'h200,      0,         0, 0);
    v(1, 1, 32'h800,       0, 0, 0, 0,           0, 32'h800,      32'h800,      0,         0, 0);
    v(0, 0, 0,             0, 0, 1, 32'h600,     0, 32'h600,      32'h600,      0,         1, 0);
    v(1, 0, 0,             0, 0, 1, 32'h900,     0, 32'h600,      32'h600,      0,         1, 0);
    v(1, 0, 0,             0, 0, 0, 0,           1, 32'h600,      32'h600,      0,         1, 0);
    v(0, 0, 0,             0, 0, 1, 32'h700,     1, 32'h700,      32'h700,      0,         2, 0);
    v(0, 0, 0,             0, 0, 0, 0,           1, 32'h604,      32'h604,      0,         1, 0);
    v(0, 0, 0,             0, 0, 0, 0,           1, 32'h804,      32'h804,      0,         0, 0);
    // trap / mret
    v(0, 1, 32'h300,       0, 0, 0, 0,           0, 32'h300,      32'h300,      0,         0, 0);
    v(0, 0, 0,             1, 0, 0, 0,           0, 32'h1000,     32'h1000,     32'h300,   0, 0);
    v(0, 0, 0,             0, 1, 0, 0,           0, 32'h300,      32'h300,      32'h300,   0, 0);
    v(0, 0, 0,             0, 0, 0, 0,           0, 32'h304,      32'h304,      32'h300,   0, 0);
    v(1, 1, 32'h900,       1, 1, 1, 32'h50,      0, 32'h1000,     32'h1000,     32'h304,   0, 0);
    v(0, 0, 0,             1, 0, 0, 0,           0, 32'h1000,     32'h1000,     32'h1000,  0, 0);
    v(1, 1, 32'h900,       0, 1, 0, 0,           0, 32'h1000,     32'h1000,     32'h1000,  0, 0);
    v(1, 1, 32'h900,       0, 0, 0, 0,           0, 32'h900,      32'h900,      32'h1000,  0, 0);
    // wrap-around of sequential increment
    v(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0,           0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h1000, 0, 0);
    v(0, 0, 0,             0, 0, 0, 0,           0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1000, 0, 0);
    v(0, 0, 0,             0, 0, 0, 0,           0, 32'h0,        32'h0,        32'h1000,  0, 0);
    v(0, 0, 0,             0, 0, 1, 32'h50,      0, 32'h50,       32'h50,       32'h1000,  1, 0);

    // reset state, held across edges
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cnt", {29'd0, ras_count}, 32'h0);
    chk("rst_empty", {31'd0, ras_empty}, 32'h1);
    chk("rst_full", {31'd0, ras_full}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_next", i), next_pc, tbl[i].e_next);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("v%0d_epc", i), epc, tbl[i].e_epc);
      chk($sformatf("v%0d_cnt", i), {29'd0, ras_count}, {29'd0, tbl[i].e_cnt});
      chk($sformatf("v%0d_full", i), {31'd0, ras_full}, {31'd0, tbl[i].e_full});
      chk($sformatf("v%0d_empty", i), {31'd0, ras_empty}, {31'd0, (tbl[i].e_cnt == 3'd0)});
      @(negedge clk);
    end

    // asynchronous reset between edges: state clears without a clock edge
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_epc", epc, 32'h0);
    chk("async_cnt", {29'd0, ras_count}, 32'h0);
    chk("async_empty", {31'd0, ras_empty}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    // ret on an empty stack after reset falls through to sequential
    ret = 1'b1;
    #1;
    chk("post_next", next_pc, 32'h4);
    @(posedge clk);
    #1;
    chk("post_pc", pc, 32'h4);
    chk("post_cnt", {29'd0, ras_count}, 32'h0);
    @(negedge clk);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage, successor to the plain PC register. Holds the current fetch address and selects the next one from sequential increment, stall hold, branch redirect, trap entry/return and call/return. Includes a saved exception PC (epc) and a small circular return-address stack (RAS) that predicts return targets. Feeds the instruction memory address and receives redirect/trap controls from later pipeline stages.

## Interface
- WIDTH, 32, address width in bits
- INC, 4, sequential increment in bytes
- RESET_VEC, 0, pc value held during reset
- TRAP_VEC, 32'h0000_1000, trap entry address (truncated to WIDTH)
- RAS_DEPTH, 4, return-address stack entries (≥2, power of two)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  hold pc and RAS (sequential, call and ret paths only)
- redirect_valid  in  1  branch/jump resolved; load redirect_target
- redirect_target  in  WIDTH  redirect address
- trap  in  1  take trap: epc <= pc, pc <= TRAP_VEC
- mret  in  1  return from trap: pc <= epc
- call  in  1  call: push pc+INC onto RAS, pc <= call_target
- call_target  in  WIDTH  call destination
- ret  in  1  return: pop RAS, pc <= popped value
- pc  out  WIDTH  current fetch address (registered)
- next_pc  out  WIDTH  address pc takes at next edge (combinational)
- epc  out  WIDTH  saved exception pc (registered)
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
- ras_empty  out  1  ras_count == 0
- ras_full  out  1  ras_count == RAS_DEPTH

## Operation
- Reset (rst low, asynchronous): pc=RESET_VEC, epc=0, ras_count=0, top pointer=0, all RAS entries=0; ras_empty=1, ras_full=0.
- Next-pc priority, highest first:
  - trap: next_pc=TRAP_VEC; epc <= pc; RAS unchanged.
  - mret: next_pc=epc; RAS unchanged.
  - redirect_valid: next_pc=redirect_target; RAS unchanged.
  - stall: next_pc=pc; RAS unchanged; call/ret ignored.
  - call: next_pc=call_target; push pc+INC.
  - ret and !ras_empty: next_pc=top entry; pop.
  - ret and ras_empty: treated as sequential; ras_count stays 0.
  - otherwise: next_pc=pc+INC.
- Trap, mret and redirect override stall. call and ret together: call wins, ret ignored.
- Arithmetic: pc+INC is modulo 2^WIDTH (0xFFFF_FFFC+4 = 0 at WIDTH=32).
- RAS: circular buffer indexed by top pointer modulo RAS_DEPTH.
  - Push: top advances, entry written, ras_count increments, saturating at RAS_DEPTH.
  - Push when full: oldest entry overwritten (wrap), ras_count stays RAS_DEPTH.
  - Pop: returns top entry, top retreats, ras_count decrements.
  - Entry contents after pop are don't-care.
- epc written only on trap; a trap while already in a trap handler overwrites epc.

## Timing
- pc, epc, RAS state are registered; update on the rising clk edge where the selecting input was sampled high.
- next_pc, ras_empty, ras_full are valid in the same cycle as their inputs; zero-cycle combinational path from controls to next_pc.
- Redirect latency: target appears on pc one cycle after redirect_valid.
- Reset asserted mid-operation: outputs reach reset values immediately, without waiting for clk. First non-reset update occurs at the first rising edge with rst high.
- No input handshakes: every control is a single-cycle level sampled at the edge.

## Test plan
- Reset then 3 free-running cycles (defaults) -> pc 0x0, 0x4, 0x8, 0xC; ras_empty=1, epc=0.
- pc=0x100, call with call_target=0x400 -> pc=0x400, ras_count=1. Then ret -> pc=0x104, ras_count=0.
- 5 calls from pc 0x0,0x10,0x20,0x30,0x40 (RAS_DEPTH=4) -> ras_full=1, ras_count=4. Then 4 rets -> pc 0x44, 0x34, 0x24, 0x14. Fifth ret with ras_empty -> pc=0x18.
- pc=0x200, stall and redirect_valid with 0x800 in same cycle -> pc=0x800. Stall+call -> pc held, ras_count unchanged.
- pc=0x300, trap -> pc=0x1000, epc=0x300. Then mret -> pc=0x300. trap+mret+redirect together -> trap wins.
- pc=0xFFFF_FFFC sequential -> pc=0x0. Assert rst low between edges mid-run -> pc=0 immediately, ras_count=0.
